// File: rtl/pmv_update_sequencer.sv
// pmv_update_sequencer
//
// Sequences the per-macroblock motion-vector predictor (PMV) update in the
// motion compensation path. The block owns two 8 x 16-bit register files:
//   - the delta buffer, loaded with decoded motion-vector deltas, and
//   - the PMV file, rewritten by the external prediction update engine.
// Once all deltas of a macroblock are in, it pulses the engine start, waits
// for the engine to go idle again, reports MB_Ready_O and clears the deltas.
// A PMV reset request (slice start, intra MB, skipped MB) is held pending and
// handed to the engine at the start of the next update.
//
// Ports
//   clock, resetn            system clock (rising edge), async active-low reset
//   F_Codes_Load_I/F_Codes_I picture-level f_codes capture
//   Delta_Write_En_I,
//   Delta_Index_I,
//   Delta_Data_I             delta buffer write port (only while Delta_Ready_O)
//   Deltas_Done_I            all deltas of the current MB loaded: run update
//   PMV_Reset_Req_I          next update treats current PMVs as zero
//   Delta_Ready_O            delta buffer writable (IDLE / COLLECT)
//   MB_Ready_O               one-cycle pulse: PMV file updated
//   PMV_Valid_O              PMV read data stable (IDLE / COLLECT)
//   PMV_Read_Index_I,
//   PMV_Read_Data_O          combinational PMV read for motion compensation
//   Eng_Start_O              one-cycle start pulse to the update engine
//   Eng_Done_I               engine idle (level)
//   Eng_Index_0_I/Eng_Delta_O    engine delta read port
//   Eng_Index_1_I/Eng_PMV_O      engine PMV read port
//   Eng_New_PMV_I/Eng_Write_En_I engine PMV write port (honoured in WAIT)
//   Eng_PMV_Reset_O          zero-PMV control, frozen for the whole update
//   Eng_F_Codes_O            registered f_codes

module pmv_update_sequencer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        F_Codes_Load_I,
  input  logic [15:0] F_Codes_I,
  input  logic        Delta_Write_En_I,
  input  logic [2:0]  Delta_Index_I,
  input  logic [15:0] Delta_Data_I,
  input  logic        Deltas_Done_I,
  input  logic        PMV_Reset_Req_I,
  output logic        Delta_Ready_O,
  output logic        MB_Ready_O,
  output logic        PMV_Valid_O,
  input  logic [2:0]  PMV_Read_Index_I,
  output logic [15:0] PMV_Read_Data_O,
  output logic        Eng_Start_O,
  input  logic        Eng_Done_I,
  input  logic [2:0]  Eng_Index_0_I,
  input  logic [2:0]  Eng_Index_1_I,
  output logic [15:0] Eng_Delta_O,
  output logic [15:0] Eng_PMV_O,
  input  logic [15:0] Eng_New_PMV_I,
  input  logic        Eng_Write_En_I,
  output logic        Eng_PMV_Reset_O,
  output logic [15:0] Eng_F_Codes_O
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] delta_buf [8];
  logic [15:0] pmv_file  [8];
  logic        reset_pending;
  logic        late_req;
  logic        delta_accept;

  // Delta_Ready_O is a registered copy of "state is IDLE or COLLECT", so it
  // doubles as the write qualifier for the delta buffer.
  assign delta_accept = Delta_Write_En_I && Delta_Ready_O;

  // Main sequencer. All status outputs are registered here so they change
  // together with the state. The zero-PMV control is captured on the edge
  // that enters START and held until the update has finished; a request that
  // arrives on that same edge still belongs to this update.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      Eng_Start_O     <= 1'b0;
      MB_Ready_O      <= 1'b0;
      Delta_Ready_O   <= 1'b1;
      PMV_Valid_O     <= 1'b1;
      Eng_PMV_Reset_O <= 1'b0;
    end else begin
      Eng_Start_O <= 1'b0;
      MB_Ready_O  <= 1'b0;
      case (state)
        S_IDLE, S_COLLECT: begin
          if (Deltas_Done_I) begin
            state           <= S_START;
            Eng_Start_O     <= 1'b1;
            Delta_Ready_O   <= 1'b0;
            PMV_Valid_O     <= 1'b0;
            Eng_PMV_Reset_O <= reset_pending | PMV_Reset_Req_I;
          end else if (delta_accept) begin
            state <= S_COLLECT;
          end
        end
        S_START: begin
          // Eng_Done_I may still be high from the previous idle period.
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (Eng_Done_I) begin
            state      <= S_DONE;
            MB_Ready_O <= 1'b1;
          end
        end
        S_DONE: begin
          state           <= S_IDLE;
          Delta_Ready_O   <= 1'b1;
          PMV_Valid_O     <= 1'b1;
          Eng_PMV_Reset_O <= 1'b0;
        end
        default: begin
          state           <= S_IDLE;
          Delta_Ready_O   <= 1'b1;
          PMV_Valid_O     <= 1'b1;
          Eng_PMV_Reset_O <= 1'b0;
        end
      endcase
    end
  end

  // Pending PMV reset. A request can come in any state. Requests seen while
  // an update is in flight are remembered in late_req so that clearing the
  // flag at the end of the update only consumes the request that update
  // actually applied.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      reset_pending <= 1'b0;
      late_req      <= 1'b0;
    end else begin
      case (state)
        S_START, S_WAIT: begin
          if (PMV_Reset_Req_I) begin
            reset_pending <= 1'b1;
            late_req      <= 1'b1;
          end
        end
        S_DONE: begin
          reset_pending <= PMV_Reset_Req_I | late_req |
                           (reset_pending & ~Eng_PMV_Reset_O);
          late_req      <= 1'b0;
        end
        default: begin
          if (PMV_Reset_Req_I) begin
            reset_pending <= 1'b1;
          end
          late_req <= 1'b0;
        end
      endcase
    end
  end

  // Delta buffer. Writes are taken only while the buffer is open; DONE
  // zeroes every entry so that indices the next MB does not write contribute
  // nothing to its update.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        delta_buf[i] <= 16'h0000;
      end
    end else if (state == S_DONE) begin
      for (int i = 0; i < 8; i++) begin
        delta_buf[i] <= 16'h0000;
      end
    end else if (delta_accept) begin
      delta_buf[Delta_Index_I] <= Delta_Data_I;
    end
  end

  // PMV file. Only the engine writes it, and only while an update is
  // running; stray engine writes outside WAIT are ignored.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        pmv_file[i] <= 16'h0000;
      end
    end else if ((state == S_WAIT) && Eng_Write_En_I) begin
      pmv_file[Eng_Index_1_I] <= Eng_New_PMV_I;
    end
  end

  // f_codes register. Loading is allowed at any time; a load during an
  // update reaches the engine immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      Eng_F_Codes_O <= 16'h0000;
    end else if (F_Codes_Load_I) begin
      Eng_F_Codes_O <= F_Codes_I;
    end
  end

  assign PMV_Read_Data_O = pmv_file[PMV_Read_Index_I];
  assign Eng_Delta_O     = delta_buf[Eng_Index_0_I];
  assign Eng_PMV_O       = pmv_file[Eng_Index_1_I];

endmodule

// File: doc/pmv_update_sequencer.md
# pmv_update_sequencer

Sequences the per-macroblock motion-vector predictor (PMV) update in the motion compensation path. Owns the 8-entry delta buffer and the 8-entry PMV file, collects decoded motion-vector deltas, and launches the 16-cycle prediction update engine. It applies pending PMV resets, for slice start, intra MB or skipped MB, to the next update. It serves predictor values to the motion compensation fetch logic.

## Interface
- No parameters; all widths are fixed.
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- F_Codes_Load_I  in  1  capture F_Codes_I; asserted once per picture header.
- F_Codes_I  in  16  four 4-bit f_codes, [15:12]=f[0][0] … [3:0]=f[1][1].
- Delta_Write_En_I  in  1  write Delta_Data_I to delta[Delta_Index_I]; honoured only while Delta_Ready_O=1.
- Delta_Index_I  in  3  delta buffer entry index.
- Delta_Data_I  in  16  [13]=sign, [12:0]=magnitude; [15:14] stored but unused.
- Deltas_Done_I  in  1  pulse: all deltas of the current MB are loaded.
- PMV_Reset_Req_I  in  1  pulse: next update treats the current PMVs as zero.
- Delta_Ready_O  out  1  delta buffer writable; high in IDLE and COLLECT.
- MB_Ready_O  out  1  one-cycle pulse: PMV file updated.
- PMV_Valid_O  out  1  PMV read data is stable; high in IDLE and COLLECT.
- PMV_Read_Index_I  in  3  motion compensation read address.
- PMV_Read_Data_O  out  16  combinational read of pmv[PMV_Read_Index_I].
- Eng_Start_O  out  1  start pulse to the update engine.
- Eng_Done_I  in  1  engine idle; level signal, low during its 16 calculation cycles.
- Eng_Index_0_I, Eng_Index_1_I  in  3  engine read/write indices.
- Eng_Delta_O  out  16  delta[Eng_Index_0_I], combinational.
- Eng_PMV_O  out  16  pmv[Eng_Index_1_I], combinational.
- Eng_New_PMV_I  in  16  engine result.
- Eng_Write_En_I  in  1  write Eng_New_PMV_I to pmv[Eng_Index_1_I].
- Eng_PMV_Reset_O  out  1  zero-PMV control to the engine.
- Eng_F_Codes_O  out  16  registered f_codes.

## Operation
- States:
  - IDLE: buffer empty since the last update.
  - COLLECT: at least one delta has been written.
  - START: Eng_Start_O=1, one cycle.
  - WAIT: engine running.
  - DONE: MB_Ready_O=1, delta buffer cleared.
- Transitions:
  - IDLE→COLLECT on an accepted delta write.
  - IDLE or COLLECT→START on Deltas_Done_I. Deltas_Done_I with no writes still runs an update; unwritten entries hold 0.
  - START→WAIT unconditionally.
  - WAIT→DONE when Eng_Done_I=1. Eng_Done_I is ignored in START.
  - DONE→IDLE unconditionally.
- A delta write and Deltas_Done_I in the same cycle: the write lands first, then the update starts.
- Delta writes in START, WAIT or DONE are dropped. The buffer is not modified.
- Reset pending flag:
  - Set by PMV_Reset_Req_I in any state.
  - Eng_PMV_Reset_O = flag, registered, held constant from START through WAIT.
  - A request arriving in START or WAIT stays pending for the next update. It does not affect the update in flight: the value driven to the engine is frozen at the START entry edge.
  - The flag clears in DONE only if it was applied; a request arriving mid-update survives.
- In DONE, all 8 delta entries are set to 0, so absent deltas leave the PMVs unchanged. The PMV file is never cleared except by resetn.
- F_Codes_Load_I is honoured in any state. Loading during WAIT is a protocol violation: the new value is applied immediately with no protection.
- Engine PMV writes are accepted only in WAIT; Eng_Write_En_I is ignored elsewhere.

## Timing
- resetn low:
  - State is IDLE; all buffers, the PMV file, f_codes and the flag are 0.
  - Eng_Start_O=0, Eng_PMV_Reset_O=0, MB_Ready_O=0.
  - Delta_Ready_O=1, PMV_Valid_O=1.
  - Reset mid-update aborts immediately; the engine must share the same reset.
- Delta and PMV register file writes occur on the rising edge; reads are combinational.
- Deltas_Done_I sampled at edge t gives:
  - START during cycle t+1.
  - Engine calculation during t+2..t+17, with Eng_Done_I low.
  - WAIT ends at the edge after t+18, when Eng_Done_I is high.
  - DONE and MB_Ready_O during cycle t+19.
  - IDLE at t+20.
- Delta_Ready_O and PMV_Valid_O drop in the cycle after the Deltas_Done_I edge. They return in IDLE (t+20).
- Back-to-back macroblocks: Deltas_Done_I is accepted again from t+20.

## Test plan
- Reset, then write delta[0]=0x0003 with f_codes=0x1111 and PMV=0, then Deltas_Done_I → pmv[0]=0x0003, pmv[1..7] unchanged, MB_Ready_O exactly 19 cycles after Deltas_Done_I.
- Preload pmv[2]=0x0010, assert PMV_Reset_Req_I, then update with delta[2]=sign-set magnitude 1 → pmv[2]=0xFFFF; flag clear afterwards.
- Assert PMV_Reset_Req_I at START+3 → current update uses Eng_PMV_Reset_O=0; the next update uses 1.
- Write to delta[5] during WAIT → write dropped, Delta_Ready_O=0; delta[5] reads 0 at the next IDLE.
- Deltas_Done_I with no delta writes → PMV file unchanged, MB_Ready_O still pulses.
- Deassert resetn at WAIT+5 → state IDLE, PMV file 0, no MB_Ready_O pulse.
